// File: rtl/mc_maindec.sv
// Main control FSM for the multicycle MIPS core.
// Moore outputs per state; write enables gated off while reset is high.
module mc_maindec #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_ORI   = 6'b001101,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    output logic       pcwrite,
    output logic       branch,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic [3:0] state
);

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] RTYPEEX = 4'd6;
    localparam logic [3:0] RTYPEWB = 4'd7;
    localparam logic [3:0] BEQEX   = 4'd8;
    localparam logic [3:0] ADDIEX  = 4'd9;
    localparam logic [3:0] IMMWB   = 4'd10;
    localparam logic [3:0] JEX     = 4'd11;
    localparam logic [3:0] ORIEX   = 4'd12;

    logic [3:0] next_state;
    logic [3:0] out_state;
    logic       pcw;
    logic       br;
    logic       irw;
    logic       memw;
    logic       regw;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:   next_state = DECODE;
            DECODE: begin
                if (op == OP_LW || op == OP_SW) next_state = MEMADR;
                else if (op == OP_RTYPE)        next_state = RTYPEEX;
                else if (op == OP_BEQ)          next_state = BEQEX;
                else if (op == OP_ADDI)         next_state = ADDIEX;
                else if (op == OP_ORI)          next_state = ORIEX;
                else if (op == OP_J)            next_state = JEX;
                else                            next_state = FETCH;
            end
            MEMADR:  next_state = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   next_state = MEMWB;
            RTYPEEX: next_state = RTYPEWB;
            ADDIEX:  next_state = IMMWB;
            ORIEX:   next_state = IMMWB;
            default: next_state = FETCH;
        endcase
    end

    // Reset shows the FETCH selects so the datapath sees a quiet fetch setup
    assign out_state = reset ? FETCH : state;

    always_comb begin
        pcw      = 1'b0;
        br       = 1'b0;
        irw      = 1'b0;
        memw     = 1'b0;
        regw     = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        case (out_state)
            FETCH: begin
                irw     = 1'b1;
                pcw     = 1'b1;
                alusrcb = 2'b01;
            end
            DECODE:  alusrcb = 2'b11;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:   iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regw     = 1'b1;
            end
            MEMWR: begin
                iord = 1'b1;
                memw = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            RTYPEWB: begin
                regdst = 1'b1;
                regw   = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                br      = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            IMMWB:   regw = 1'b1;
            JEX: begin
                pcsrc = 2'b10;
                pcw   = 1'b1;
            end
            ORIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = 2'b11;
            end
            default: ;
        endcase
    end

    assign pcwrite  = pcw  & ~reset;
    assign branch   = br   & ~reset;
    assign irwrite  = irw  & ~reset;
    assign memwrite = memw & ~reset;
    assign regwrite = regw & ~reset;

endmodule

// File: doc/mc_maindec.md
Name: mc_maindec

Overview:
- Moore control FSM for the multicycle MIPS core. It sits directly upstream of the ALU decoder.
- Decodes the 6-bit opcode, sequences each instruction through fetch, decode, execute, memory and writeback cycles, and drives every datapath enable and mux select.
- Produces the 2-bit aluop consumed by the ALU decoder: 00 add, 01 sub/beq, 10 use funct, 11 or.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch if equal
- OP_ADDI, 6'b001000, add immediate
- OP_ORI, 6'b001101, or immediate
- OP_J, 6'b000010, jump

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- op  in  6  opcode, instr[31:26], from instruction register
- pcwrite  out  1  unconditional PC write enable
- branch  out  1  conditional PC write; datapath ANDs with zero
- irwrite  out  1  instruction register write enable
- memwrite  out  1  memory write enable
- regwrite  out  1  register file write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memtoreg  out  1  writeback data select: 0 = ALUOut, 1 = Data
- regdst  out  1  destination register select: 0 = rt, 1 = rd
- alusrca  out  1  ALU A select: 0 = PC, 1 = A
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- aluop  out  2  to ALU decoder
- state  out  4  current state, for debug and bench observation

Behaviour:
State encoding and Moore outputs. Any output not listed is 0.
- FETCH = 0: irwrite=1, pcwrite=1, alusrcb=01.
- DECODE = 1: alusrcb=11.
- MEMADR = 2: alusrca=1, alusrcb=10.
- MEMRD = 3: iord=1.
- MEMWB = 4: memtoreg=1, regwrite=1.
- MEMWR = 5: iord=1, memwrite=1.
- RTYPEEX = 6: alusrca=1, aluop=10.
- RTYPEWB = 7: regdst=1, regwrite=1.
- BEQEX = 8: alusrca=1, aluop=01, pcsrc=01, branch=1.
- ADDIEX = 9: alusrca=1, alusrcb=10.
- IMMWB = 10: regwrite=1 (regdst=0, memtoreg=0). Shared by addi and ori.
- JEX = 11: pcsrc=10, pcwrite=1.
- ORIEX = 12: alusrca=1, alusrcb=10, aluop=11.
- Codes 13–15 are illegal. They decode to all-zero outputs and next state FETCH.

Transitions:
- FETCH -> DECODE.
- DECODE dispatches on op:
  - LW/SW -> MEMADR
  - RTYPE -> RTYPEEX
  - BEQ -> BEQEX
  - ADDI -> ADDIEX
  - ORI -> ORIEX
  - J -> JEX
  - any other opcode -> FETCH (instruction skipped, no architectural write)
- MEMADR: op==LW -> MEMRD, otherwise -> MEMWR.
- MEMRD -> MEMWB.
- RTYPEEX -> RTYPEWB.
- ADDIEX -> IMMWB.
- ORIEX -> IMMWB.
- MEMWB, MEMWR, RTYPEWB, IMMWB, BEQEX, JEX -> FETCH.

Timing:
- op is sampled only in DECODE and MEMADR. The IR holds it stable because irwrite is asserted only in FETCH.
- Cycles per instruction, FETCH to next FETCH: lw 5, sw 4, R-type 4, addi 4, ori 4, beq 3, j 3, unknown opcode 2.
- Outputs are a pure function of state, except during reset (below). There is no combinational path from op to any output.

Reset:
- At a rising edge with reset=1, state <= FETCH, regardless of current state (including mid-instruction).
- While reset=1, pcwrite, branch, irwrite, memwrite and regwrite are forced to 0 combinationally. This stops FETCH from advancing the PC during reset.
- All mux selects and aluop show FETCH values during reset.
- First real fetch happens in the first cycle after reset deasserts.
- Reset asserted in MEMWR or RTYPEWB suppresses that cycle's write immediately.

Test Plan:
- reset=1 for 2 cycles with op=X, then release -> during reset: state=0, all five enables 0. First post-reset cycle: irwrite=1, pcwrite=1, alusrcb=01.
- op=100011 (lw) -> state trace 0,1,2,3,4,0. In state 3: iord=1. In state 4: regwrite=1, memtoreg=1. aluop=00 throughout.
- op=000000 (R-type), then op=101011 (sw) -> R-type trace 0,1,6,7,0 with aluop=10 in state 6 and regdst=1, regwrite=1 in state 7. Then sw trace 0,1,2,5,0 with memwrite=1 and iord=1 only in state 5.
- op=000100 (beq), then op=000010 (j) -> beq trace 0,1,8,0 with branch=1, pcsrc=01, aluop=01 in state 8. Then j trace 0,1,11,0 with pcwrite=1, pcsrc=10 in state 11.
- op=001101 (ori), then op=001000 (addi) -> ori trace 0,1,12,10,0 with aluop=11, alusrcb=10 in state 12. addi trace 0,1,9,10,0 with aluop=00. regwrite=1 and regdst=0 in state 10 for both.
- op=111111 (illegal) -> trace 0,1,0 with no write enable asserted in state 1. Separately, assert reset during state 4 of lw -> regwrite drops to 0 that cycle and state=0 next edge.
